cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//  Exception/interrupt controller (CP0) at the M stage of the 5-stage MIPS pipeline.
//  Takes the merged per-instruction ExcCode (F/D/E/M priority already resolved, 0 = none)
//  and the 6 hardware interrupt lines, and decides whether to take an exception, interrupt or ERET.
//  Owns SR/Cause/EPC and produces the pipeline-wide flush + redirect request.
// PARAMETERS
//  HANDLER_ADDR  32'h0000_4180  redirect target on exception/interrupt
//  HWINT_W       6              number of hardware interrupt lines
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   synchronous, active-low: state cleared on edge where reset==0
//  valid_m     in   1   M stage holds a real instruction (0 = bubble)
//  pc_m        in   32  PC of M-stage instruction
//  bd_m        in   1   M-stage instruction sits in a delay slot
//  exc_code_m  in   5   merged exception code of M-stage instruction, 0 = none
//  eret_m      in   1   M-stage instruction is ERET
//  hw_int      in   6   hardware interrupt lines, level sensitive
//  cp0_we      in   1   MTC0 write enable (M stage)
//  cp0_addr    in   5   CP0 register number for MTC0/MFC0
//  cp0_wdata   in   32  MTC0 data
//  cp0_rdata   out  32  MFC0 data, combinational from cp0_addr
//  req         out  1   flush F..M and redirect fetch this cycle
//  redirect_pc out  32  HANDLER_ADDR on exception/interrupt, EPC on ERET
//  epc         out  32  current EPC
//  exl         out  1   SR.EXL
// BEHAVIOUR
//  - Regs: SR(12)={IM[15:10],EXL[1],IE[0]}, Cause(13)={BD[31],IP[15:10],ExcCode[6:2]}, EPC(14).
//    Other bits read 0; other addresses read 0. MTC0 to Cause writes nothing.
//  - Reset: SR=0, Cause=0, EPC=0, last_pc=HANDLER_ADDR-... no: last_pc=32'h0000_3000,
//    last_bd=0, state=NORMAL; req=0 and redirect_pc=0 while reset==0.
//  - FSM: NORMAL (EXL=0) -> HANDLER on any taken exception/interrupt; HANDLER -> NORMAL on ERET.
//    state and SR.EXL are the same bit; MTC0 to SR may also set/clear EXL directly.
//  - last_pc/last_bd: updated with pc_m/bd_m every cycle valid_m==1; used as victim PC
//    when M holds a bubble (interrupt between instructions).
//  - int_take = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
//    exc_take = (exc_code_m!=0) & valid_m & ~SR.EXL & ~int_take.
//  - Priority: int_take > exc_take > eret_m(valid_m) > MTC0. req = int_take|exc_take|eret.
//  - Take (int or exc), at next edge: EXL<=1; Cause.ExcCode<=int?0:exc_code_m;
//    Cause.BD<=victim_bd; EPC<={victim_pc - (victim_bd?4:0)}[31:2],2'b00;
//    victim = valid_m ? (pc_m,bd_m) : (last_pc,last_bd). MTC0 in same cycle is dropped.
//  - ERET (valid_m & eret_m & ~int_take): req=1, redirect_pc=EPC, EXL<=0 at next edge.
//  - Cause.IP<=hw_int every cycle, independent of masks and of any take.
//  - MTC0 to EPC writes {wdata[31:2],2'b00}; MTC0 effect visible on cp0_rdata next cycle.
//  - Latency: req/redirect_pc combinational in same cycle as trigger; register updates 1 edge later.
//  - Simultaneous hw_int and exc_code_m!=0: interrupt taken, ExcCode=0, EPC=pc_m
//    (faulting instruction re-executes after ERET).
//  - exc_code_m!=0 while EXL=1: ignored, no req (nested exceptions unsupported).
//  - reset==0 mid-handler: EXL cleared, FSM to NORMAL, pending interrupt re-evaluated after release.
// TESTING
//  1 Reset: reset=0 one edge -> cp0_rdata for 12/13/14 = 0, req=0, exl=0.
//  2 MTC0 SR=32'h0000_0401, hw_int=6'b000001 -> req=1, redirect_pc=32'h4180, next cycle
//    exl=1, Cause[6:2]=0, EPC=pc_m.
//  3 exc_code_m=5'd12, pc_m=32'h3010, bd_m=1 -> req=1, EPC=32'h300C, Cause=32'h8000_0030.
//  4 Same cycle exc_code_m=4 and unmasked hw_int -> interrupt wins, ExcCode=0, EPC=pc_m.
//  5 In handler, exc_code_m=10 -> req=0; then ERET -> req=1, redirect_pc=EPC, exl=0 next cycle.
//  6 valid_m=0 bubble after pc 32'h3020 with hw_int -> EPC=32'h3020; reset=0 in handler clears EXL.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at M: owns SR/Cause/EPC, raises flush+redirect (req) combinationally,
// registers update on the following edge; no backpressure, the pipeline must honour req in the same cycle.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          HWINT_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_m,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic [4:0]         exc_code_m,
    input  logic               eret_m,
    input  logic [HWINT_W-1:0] hw_int,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               req,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        epc,
    output logic               exl
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [HWINT_W-1:0] im, ip;
    logic               ie, bd;
    logic [4:0]         exc_code;
    logic [31:0]        epc_q, last_pc, victim_pc, epc_new;
    logic               last_bd, victim_bd;
    logic               int_take, exc_take, eret_take, take, mtc0;

    // The FSM state bit doubles as SR.EXL.
    assign exl       = (state == HANDLER);
    assign int_take  = (|(hw_int & im)) & ie & ~exl;
    assign exc_take  = valid_m & (exc_code_m != 5'd0) & ~exl & ~int_take;
    assign eret_take = valid_m & eret_m & ~int_take & ~exc_take;
    assign take      = int_take | exc_take;
    assign mtc0      = cp0_we & ~take & ~eret_take;

    // A bubble in M means the interrupt lands between instructions: blame the last real one.
    assign victim_pc = valid_m ? pc_m : last_pc;
    assign victim_bd = valid_m ? bd_m : last_bd;
    assign epc_new   = victim_pc - (victim_bd ? 32'd4 : 32'd0);

    assign req         = reset & (take | eret_take);
    assign redirect_pc = !reset   ? 32'd0 :
                         take      ? HANDLER_ADDR :
                         eret_take ? epc_q : 32'd0;
    assign epc         = epc_q;

    always_comb begin
        state_nxt = state;
        if (take)
            state_nxt = HANDLER;
        else if (eret_take)
            state_nxt = NORMAL;
        else if (mtc0 && cp0_addr == REG_SR)
            state_nxt = state_t'(cp0_wdata[1]);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= NORMAL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im       <= '0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= 5'd0;
            epc_q    <= 32'd0;
            last_pc  <= RESET_PC;
            last_bd  <= 1'b0;
        end else begin
            ip <= hw_int;
            if (valid_m) begin
                last_pc <= pc_m;
                last_bd <= bd_m;
            end
            if (take) begin
                bd       <= victim_bd;
                exc_code <= int_take ? 5'd0 : exc_code_m;
                epc_q    <= epc_new & 32'hFFFF_FFFC;
            end else if (mtc0) begin
                if (cp0_addr == REG_SR) begin
                    im <= cp0_wdata[10 +: HWINT_W];
                    ie <= cp0_wdata[0];
                end
                if (cp0_addr == REG_EPC)
                    epc_q <= cp0_wdata & 32'hFFFF_FFFC;
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            REG_SR:    cp0_rdata = {16'd0, im, 8'd0, exl, ie};
            REG_CAUSE: cp0_rdata = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            REG_EPC:   cp0_rdata = epc_q;
            default:   cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized traffic against a word-level CP0 model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, bd_m, eret_m, cp0_we;
    logic [31:0] pc_m, cp0_wdata;
    logic [4:0]  exc_code_m, cp0_addr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata, redirect_pc, epc;
    logic        req, exl;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: whole register words as software would see them.
    logic [31:0] m_sr, m_cause, m_epc, m_lpc;
    logic        m_lbd;
    logic        e_int, e_exc, e_eret, e_req;
    logic [31:0] e_red;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .eret_m(eret_m), .hw_int(hw_int), .cp0_we(cp0_we),
        .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .req(req),
        .redirect_pc(redirect_pc), .epc(epc), .exl(exl)
    );

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_eval();
        logic pend;
        pend   = ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        e_int  = reset && pend;
        e_exc  = reset && valid_m && exc_code_m != 5'd0 && !m_sr[1] && !e_int;
        e_eret = reset && valid_m && eret_m && !e_int && !e_exc;
        e_req  = e_int || e_exc || e_eret;
        e_red  = (e_int || e_exc) ? HANDLER : (e_eret ? m_epc : 32'd0);
    endtask

    task automatic model_commit();
        logic [31:0] vpc;
        logic        vbd;
        if (!reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_lpc = 32'h3000; m_lbd = 0;
            return;
        end
        vpc = valid_m ? pc_m : m_lpc;
        vbd = valid_m ? bd_m : m_lbd;
        if (e_int || e_exc) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (32'(vbd) << 31) | (32'(e_int ? 5'd0 : exc_code_m) << 2);
            m_epc   = (vpc - (vbd ? 32'd4 : 32'd0)) & ~32'd3;
        end else if (e_eret) begin
            m_sr = m_sr & ~32'h2;
        end else if (cp0_we) begin
            if (cp0_addr == 5'd12) m_sr  = cp0_wdata & 32'h0000_FC03;
            if (cp0_addr == 5'd14) m_epc = cp0_wdata & ~32'd3;
        end
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
        if (valid_m) begin
            m_lpc = pc_m;
            m_lbd = bd_m;
        end
    endtask

    // Called just after a falling edge; leaves inputs settled and the model's prediction ready.
    task automatic drive(input logic rst, input logic v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] ec, input logic er, input logic [5:0] hw,
                         input logic we, input logic [4:0] ad, input logic [31:0] wd);
        reset = rst; valid_m = v; pc_m = pc; bd_m = bd; exc_code_m = ec; eret_m = er;
        hw_int = hw; cp0_we = we; cp0_addr = ad; cp0_wdata = wd;
        #1;
        model_eval();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [4:0] ad);
        cp0_addr = ad;
        cp0_we   = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 1, 32'h3000, 1, 5'd4, 1, 6'h3F, 1, 5'd12, 32'hFFFF_FFFF);
        n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b want 0", req); end
        n_checks++;
        if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
        cyc();
        for (int a = 12; a <= 14; a++) begin
            read_reg(5'(a));
            n_checks++;
            if (cp0_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_reg%0d got %h want 0", a, cp0_rdata); end
        end
        n_checks++;
        if (exl !== 1'b0) begin n_errors++; $display("FAIL reset_exl got %b want 0", exl); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_int();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 6'b000001, 1, 5'd12, 32'h0000_0401);
        cyc();
        drive(1, 1, 32'h3100, 0, 0, 0, 6'b000001, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b1 || redirect_pc !== HANDLER) begin
            n_errors++; $display("FAIL int_req got %b/%h want 1/%h", req, redirect_pc, HANDLER);
        end
        cyc();
        n_checks++;
        if (exl !== 1'b1) begin n_errors++; $display("FAIL int_exl got %b want 1", exl); end
        read_reg(5'd13);
        n_checks++;
        if (cp0_rdata[6:2] !== 5'd0) begin n_errors++; $display("FAIL int_code got %0d want 0", cp0_rdata[6:2]); end
        n_checks++;
        if (epc !== 32'h3100) begin n_errors++; $display("FAIL int_epc got %h want 3100", epc); end
    endtask

    task automatic test_exc_bd();
        do_reset();
        drive(1, 1, 32'h3010, 1, 5'd12, 0, 0, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b1 || redirect_pc !== HANDLER) begin
            n_errors++; $display("FAIL exc_req got %b/%h want 1/%h", req, redirect_pc, HANDLER);
        end
        cyc();
        n_checks++;
        if (epc !== 32'h300C) begin n_errors++; $display("FAIL exc_epc got %h want 300c", epc); end
        read_reg(5'd13);
        n_checks++;
        if (cp0_rdata !== 32'h8000_0030) begin n_errors++; $display("FAIL exc_cause got %h want 80000030", cp0_rdata); end
    endtask

    task automatic test_int_vs_exc();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd12, 32'h0000_FC01);
        cyc();
        drive(1, 1, 32'h3040, 0, 5'd4, 0, 6'b100000, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL both_req got %b want 1", req); end
        cyc();
        read_reg(5'd13);
        n_checks++;
        if (cp0_rdata !== 32'h0000_8000) begin n_errors++; $display("FAIL both_cause got %h want 00008000", cp0_rdata); end
        n_checks++;
        if (epc !== 32'h3040) begin n_errors++; $display("FAIL both_epc got %h want 3040", epc); end
    endtask

    task automatic test_nested_eret();
        drive(1, 1, 32'h4180, 0, 5'd10, 0, 0, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL nested_req got %b want 0", req); end
        cyc();
        n_checks++;
        if (exl !== 1'b1 || epc !== 32'h3040) begin
            n_errors++; $display("FAIL nested_state got exl=%b epc=%h want 1/3040", exl, epc);
        end
        drive(1, 1, 32'h4184, 0, 0, 1, 0, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b1 || redirect_pc !== 32'h3040) begin
            n_errors++; $display("FAIL eret_req got %b/%h want 1/3040", req, redirect_pc);
        end
        cyc();
        n_checks++;
        if (exl !== 1'b0) begin n_errors++; $display("FAIL eret_exl got %b want 0", exl); end
    endtask

    task automatic test_bubble_reset();
        do_reset();
        drive(1, 1, 32'h3020, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0401);
        cyc();
        drive(1, 0, 32'h9999_0000, 1, 0, 0, 6'b000001, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b1) begin n_errors++; $display("FAIL bubble_req got %b want 1", req); end
        cyc();
        n_checks++;
        if (epc !== 32'h3020 || exl !== 1'b1) begin
            n_errors++; $display("FAIL bubble_epc got %h/%b want 3020/1", epc, exl);
        end
        drive(0, 0, 0, 0, 0, 0, 6'b000001, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL midreset_req got %b want 0", req); end
        cyc();
        n_checks++;
        if (exl !== 1'b0) begin n_errors++; $display("FAIL midreset_exl got %b want 0", exl); end
        drive(1, 0, 0, 0, 0, 0, 6'b000001, 0, 5'd0, 0);
        n_checks++;
        if (req !== 1'b0) begin n_errors++; $display("FAIL postreset_req got %b want 0", req); end
        cyc();
    endtask

    task automatic test_random();
        logic [4:0]  ad, ec;
        logic [5:0]  hw;
        logic [31:0] pc, wd;
        int          r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 3);
            ad = (r == 3) ? 5'($urandom) : 5'(12 + r);
            ec = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            pc = $urandom & 32'h0000_FFFC;
            wd = $urandom;
            drive(($urandom_range(0, 49) != 0), 1'($urandom), pc, 1'($urandom), ec,
                  ($urandom_range(0, 7) == 0), hw, ($urandom_range(0, 3) == 0), ad, wd);
            n_checks++;
            if (req !== e_req || redirect_pc !== e_red) begin
                n_errors++;
                $display("FAIL rnd_req[%0d] got %b/%h want %b/%h", i, req, redirect_pc, e_req, e_red);
            end
            n_checks++;
            if (cp0_rdata !== model_read(ad)) begin
                n_errors++;
                $display("FAIL rnd_rdata[%0d] addr %0d got %h want %h", i, ad, cp0_rdata, model_read(ad));
            end
            cyc();
            n_checks++;
            if (epc !== m_epc || exl !== m_sr[1]) begin
                n_errors++;
                $display("FAIL rnd_state[%0d] got epc=%h exl=%b want %h/%b", i, epc, exl, m_epc, m_sr[1]);
            end
        end
    endtask

    initial begin
        reset = 0; valid_m = 0; pc_m = 0; bd_m = 0; exc_code_m = 0; eret_m = 0;
        hw_int = 0; cp0_we = 0; cp0_addr = 0; cp0_wdata = 0;
        m_sr = 0; m_cause = 0; m_epc = 0; m_lpc = 32'h3000; m_lbd = 0;
        @(negedge clk);
        test_reset();
        test_int();
        test_exc_bd();
        test_int_vs_exc();
        test_nested_eret();
        test_bubble_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
